// File: rtl/miriscv_issue_ctrl.sv
// Issue/hazard controller: tracks in-flight destinations through the EX/WB pipe,
// selects operand forwarding and produces boot/stall/kill controls for fetch and decode.
module miriscv_issue_ctrl #(
   parameter int GPR_ADDR_WIDTH = 5,
   parameter int EX_DEPTH       = 2,
   parameter int BOOT_CYCLES    = 2,
   localparam int FWD_W         = $clog2(EX_DEPTH + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      d_valid_i,
   input  logic                      d_rs1_re_i,
   input  logic                      d_rs2_re_i,
   input  logic [GPR_ADDR_WIDTH-1:0] d_rs1_addr_i,
   input  logic [GPR_ADDR_WIDTH-1:0] d_rs2_addr_i,
   input  logic                      d_rd_we_i,
   input  logic [GPR_ADDR_WIDTH-1:0] d_rd_addr_i,
   input  logic                      d_load_i,
   input  logic                      ex_redirect_i,
   input  logic                      lsu_stall_i,
   input  logic                      mdu_stall_i,
   output logic                      issue_o,
   output logic [FWD_W-1:0]          fwd_rs1_sel_o,
   output logic [FWD_W-1:0]          fwd_rs2_sel_o,
   output logic [EX_DEPTH-1:0]       pipe_valid_o,
   output logic                      wb_we_o,
   output logic [GPR_ADDR_WIDTH-1:0] wb_rd_addr_o,
   output logic                      cu_boot_addr_load_en_o,
   output logic                      cu_stall_f_o,
   output logic                      cu_stall_d_o,
   output logic                      cu_kill_f_o,
   output logic                      cu_kill_d_o
);

   localparam int CNT_W = $clog2(BOOT_CYCLES + 1);

   typedef struct packed {
      logic                      valid;
      logic                      we;
      logic [GPR_ADDR_WIDTH-1:0] rd;
      logic                      load;
   } sb_entry_t;

   typedef struct packed {
      logic [FWD_W-1:0] sel;
      logic             load_use;
   } fwd_t;

   sb_entry_t        sb_q [EX_DEPTH];
   sb_entry_t        sb_d [EX_DEPTH];
   logic [CNT_W-1:0] boot_cnt_q;
   logic [CNT_W-1:0] boot_cnt_d;

   logic boot_en;
   logic back_stall;
   logic hz;
   logic stall;
   logic kill;
   logic issue;
   fwd_t rs1_fwd;
   fwd_t rs2_fwd;

   // Scan oldest to youngest so the youngest matching producer overrides.
   function automatic fwd_t lookup(input logic                      re,
                                   input logic [GPR_ADDR_WIDTH-1:0] addr,
                                   input sb_entry_t                 sb [EX_DEPTH]);
      fwd_t r;
      r = '0;
      for (int k = EX_DEPTH - 1; k >= 0; k--) begin
         if (re && (addr != '0) && sb[k].valid && sb[k].we && (sb[k].rd == addr)) begin
            r.sel      = FWD_W'(k + 1);
            r.load_use = sb[k].load && (k < EX_DEPTH - 1);
         end
      end
      return r;
   endfunction

   always_comb begin
      boot_en    = (boot_cnt_q < CNT_W'(BOOT_CYCLES));
      back_stall = lsu_stall_i | mdu_stall_i;
      rs1_fwd    = lookup(d_rs1_re_i, d_rs1_addr_i, sb_q);
      rs2_fwd    = lookup(d_rs2_re_i, d_rs2_addr_i, sb_q);
      hz         = rs1_fwd.load_use | rs2_fwd.load_use;
      stall      = boot_en | back_stall | (d_valid_i & hz);
      kill       = ex_redirect_i & ~back_stall & ~boot_en;
      issue      = d_valid_i & ~stall & ~kill;
   end

   always_comb begin
      boot_cnt_d = boot_cnt_q;
      if (boot_en) begin
         boot_cnt_d = boot_cnt_q + CNT_W'(1);
      end
   end

   // A frozen back end holds every entry, so a hazard stall under back_stall inserts no bubble.
   always_comb begin
      sb_d = sb_q;
      if (!back_stall) begin
         for (int k = EX_DEPTH - 1; k > 0; k--) begin
            sb_d[k] = sb_q[k-1];
         end
         sb_d[0] = '0;
         if (issue) begin
            sb_d[0].valid = 1'b1;
            sb_d[0].we    = d_rd_we_i;
            sb_d[0].rd    = d_rd_addr_i;
            sb_d[0].load  = d_load_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         boot_cnt_q <= '0;
         for (int k = 0; k < EX_DEPTH; k++) begin
            sb_q[k] <= '0;
         end
      end else begin
         boot_cnt_q <= boot_cnt_d;
         for (int k = 0; k < EX_DEPTH; k++) begin
            sb_q[k] <= sb_d[k];
         end
      end
   end

   always_comb begin
      pipe_valid_o = '0;
      for (int k = 0; k < EX_DEPTH; k++) begin
         pipe_valid_o[k] = sb_q[k].valid;
      end
   end

   assign issue_o                = issue;
   assign fwd_rs1_sel_o          = rs1_fwd.sel;
   assign fwd_rs2_sel_o          = rs2_fwd.sel;
   assign wb_we_o                = sb_q[EX_DEPTH-1].valid & sb_q[EX_DEPTH-1].we & ~back_stall
                                   & (sb_q[EX_DEPTH-1].rd != '0);
   assign wb_rd_addr_o           = sb_q[EX_DEPTH-1].rd;
   assign cu_boot_addr_load_en_o = boot_en;
   assign cu_stall_f_o           = stall;
   assign cu_stall_d_o           = stall;
   assign cu_kill_f_o            = kill;
   assign cu_kill_d_o            = kill;

endmodule

// File: tb/tb_miriscv_issue_ctrl.sv
// Randomized bench: two controllers (EX_DEPTH=2 and 4) share stimulus and are checked
// against an age-based model of in-flight instructions.
module tb_miriscv_issue_ctrl;

   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, d_valid, rs1_re, rs2_re, rd_we, load, redirect, lsu_stall, mdu_stall;
   logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;

   logic          a_issue, a_wbwe, a_boot, a_sf, a_sd, a_kf, a_kd;
   logic [1:0]    a_fwd1, a_fwd2, a_pv;
   logic [AW-1:0] a_wbrd;
   logic          b_issue, b_wbwe, b_boot, b_sf, b_sd, b_kf, b_kd;
   logic [2:0]    b_fwd1, b_fwd2;
   logic [3:0]    b_pv;
   logic [AW-1:0] b_wbrd;

   miriscv_issue_ctrl #(.GPR_ADDR_WIDTH(AW), .EX_DEPTH(2), .BOOT_CYCLES(2)) dut_d2 (
      .clk_i(clk), .rst_i(rst), .d_valid_i(d_valid),
      .d_rs1_re_i(rs1_re), .d_rs2_re_i(rs2_re),
      .d_rs1_addr_i(rs1_addr), .d_rs2_addr_i(rs2_addr),
      .d_rd_we_i(rd_we), .d_rd_addr_i(rd_addr), .d_load_i(load),
      .ex_redirect_i(redirect), .lsu_stall_i(lsu_stall), .mdu_stall_i(mdu_stall),
      .issue_o(a_issue), .fwd_rs1_sel_o(a_fwd1), .fwd_rs2_sel_o(a_fwd2),
      .pipe_valid_o(a_pv), .wb_we_o(a_wbwe), .wb_rd_addr_o(a_wbrd),
      .cu_boot_addr_load_en_o(a_boot), .cu_stall_f_o(a_sf), .cu_stall_d_o(a_sd),
      .cu_kill_f_o(a_kf), .cu_kill_d_o(a_kd));

   miriscv_issue_ctrl #(.GPR_ADDR_WIDTH(AW), .EX_DEPTH(4), .BOOT_CYCLES(2)) dut_d4 (
      .clk_i(clk), .rst_i(rst), .d_valid_i(d_valid),
      .d_rs1_re_i(rs1_re), .d_rs2_re_i(rs2_re),
      .d_rs1_addr_i(rs1_addr), .d_rs2_addr_i(rs2_addr),
      .d_rd_we_i(rd_we), .d_rd_addr_i(rd_addr), .d_load_i(load),
      .ex_redirect_i(redirect), .lsu_stall_i(lsu_stall), .mdu_stall_i(mdu_stall),
      .issue_o(b_issue), .fwd_rs1_sel_o(b_fwd1), .fwd_rs2_sel_o(b_fwd2),
      .pipe_valid_o(b_pv), .wb_we_o(b_wbwe), .wb_rd_addr_o(b_wbrd),
      .cu_boot_addr_load_en_o(b_boot), .cu_stall_f_o(b_sf), .cu_stall_d_o(b_sd),
      .cu_kill_f_o(b_kf), .cu_kill_d_o(b_kd));

   // One in-flight instruction: age = number of unfrozen cycles since it left decode.
   typedef struct packed {
      logic [AW-1:0] rd;
      logic          we;
      logic          ld;
      logic [3:0]    age;
   } rec_t;

   rec_t m [2][8];
   int   m_n [2];
   int   depth [2];
   int   boot_cnt;
   bit   exp_issue [2];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk_eq(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void lookup(input int i, input bit re, input int addr,
                                  output int fwd, output bit lu);
      int best;
      best = 99;
      fwd  = 0;
      lu   = 1'b0;
      if (re && addr != 0) begin
         for (int j = 0; j < m_n[i]; j++) begin
            if (m[i][j].we && int'(m[i][j].rd) == addr && int'(m[i][j].age) < best) begin
               best = int'(m[i][j].age);
               lu   = m[i][j].ld && (best < depth[i] - 1);
            end
         end
         if (best != 99) fwd = best + 1;
      end
   endfunction

   task automatic eval_and_check(input int i);
      bit bs, boot, lu1, lu2, stall, kill, issue, wbwe, wbhas;
      int fwd1, fwd2, pv, wbrd;
      int a_is, a_st_f, a_st_d, a_k_f, a_k_d, a_bt, a_f1, a_f2, a_p, a_we, a_rd;
      string s;
      bs    = lsu_stall | mdu_stall;
      boot  = boot_cnt < 2;
      lookup(i, rs1_re, int'(rs1_addr), fwd1, lu1);
      lookup(i, rs2_re, int'(rs2_addr), fwd2, lu2);
      stall = boot | bs | (d_valid & (lu1 | lu2));
      kill  = redirect & ~bs & ~boot;
      issue = d_valid & ~stall & ~kill;
      pv    = 0;
      wbhas = 1'b0;
      wbwe  = 1'b0;
      wbrd  = 0;
      for (int j = 0; j < m_n[i]; j++) begin
         pv = pv | (1 << m[i][j].age);
         if (int'(m[i][j].age) == depth[i] - 1) begin
            wbhas = 1'b1;
            wbrd  = int'(m[i][j].rd);
            wbwe  = m[i][j].we && !bs && (m[i][j].rd != 0);
         end
      end
      exp_issue[i] = issue;
      if (i == 0) begin
         a_is = a_issue; a_st_f = a_sf; a_st_d = a_sd; a_k_f = a_kf; a_k_d = a_kd; a_bt = a_boot;
         a_f1 = a_fwd1; a_f2 = a_fwd2; a_p = a_pv; a_we = a_wbwe; a_rd = a_wbrd;
      end else begin
         a_is = b_issue; a_st_f = b_sf; a_st_d = b_sd; a_k_f = b_kf; a_k_d = b_kd; a_bt = b_boot;
         a_f1 = b_fwd1; a_f2 = b_fwd2; a_p = b_pv; a_we = b_wbwe; a_rd = b_wbrd;
      end
      s = $sformatf("d%0d", depth[i]);
      chk_eq({s, "_issue"},   a_is,   int'(issue));
      chk_eq({s, "_stall_f"}, a_st_f, int'(stall));
      chk_eq({s, "_stall_d"}, a_st_d, int'(stall));
      chk_eq({s, "_kill_f"},  a_k_f,  int'(kill));
      chk_eq({s, "_kill_d"},  a_k_d,  int'(kill));
      chk_eq({s, "_boot"},    a_bt,   int'(boot));
      chk_eq({s, "_pvalid"},  a_p,    pv);
      chk_eq({s, "_wb_we"},   a_we,   int'(wbwe));
      if (wbhas) chk_eq({s, "_wb_rd"}, a_rd, wbrd);
      if (d_valid && !lu1) chk_eq({s, "_fwd1"}, a_f1, fwd1);
      if (d_valid && !lu2) chk_eq({s, "_fwd2"}, a_f2, fwd2);
   endtask

   task automatic advance_model();
      int k;
      if (rst) begin
         m_n[0]   = 0;
         m_n[1]   = 0;
         boot_cnt = 0;
      end else begin
         if (boot_cnt < 2) boot_cnt++;
         for (int i = 0; i < 2; i++) begin
            if (!(lsu_stall | mdu_stall)) begin
               k = 0;
               for (int j = 0; j < m_n[i]; j++) begin
                  if (int'(m[i][j].age) + 1 < depth[i]) begin
                     m[i][k]     = m[i][j];
                     m[i][k].age = m[i][j].age + 4'd1;
                     k++;
                  end
               end
               m_n[i] = k;
               if (exp_issue[i]) begin
                  m[i][k] = '{rd: rd_addr, we: rd_we, ld: load, age: 4'd0};
                  m_n[i]  = k + 1;
               end
            end
         end
      end
   endtask

   function automatic logic [AW-1:0] rand_reg();
      if ($urandom_range(0, 9) == 0) return AW'($urandom_range(0, 31));
      return AW'($urandom_range(0, 3));
   endfunction

   initial begin
      depth[0] = 2;
      depth[1] = 4;
      rst = 1'b1; d_valid = 1'b1; rs1_re = 1'b0; rs2_re = 1'b0; rd_we = 1'b0; load = 1'b0;
      redirect = 1'b0; lsu_stall = 1'b0; mdu_stall = 1'b0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
      m_n[0] = 0; m_n[1] = 0; boot_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_boot",  int'(a_boot), 1);
      chk_eq("rst_stall", int'(a_sd),   1);
      chk_eq("rst_kill",  int'(a_kd),   0);
      chk_eq("rst_issue", int'(a_issue), 0);
      chk_eq("rst_pv",    int'(a_pv),   0);
      chk_eq("rst_wbwe",  int'(a_wbwe), 0);
      chk_eq("rst_wbrd",  int'(a_wbrd), 0);
      chk_eq("rst_fwd1",  int'(a_fwd1), 0);
      chk_eq("rst_pv4",   int'(b_pv),   0);
      for (int c = 0; c < 3000; c++) begin
         rst      = (c >= 10) && ($urandom_range(0, 199) == 0);
         d_valid  = (c < 3) || ($urandom_range(0, 3) != 0);
         rs1_re   = $urandom_range(0, 3) != 0;
         rs2_re   = $urandom_range(0, 1) != 0;
         rs1_addr = rand_reg();
         rs2_addr = ($urandom_range(0, 4) == 0) ? rs1_addr : rand_reg();
         rd_we    = $urandom_range(0, 4) != 0;
         rd_addr  = rand_reg();
         load     = $urandom_range(0, 2) == 0;
         redirect  = (c >= 3) && ($urandom_range(0, 9) == 0);
         lsu_stall = (c >= 3) && ($urandom_range(0, 9) == 0);
         mdu_stall = (c >= 3) && ($urandom_range(0, 11) == 0);
         #2;
         eval_and_check(0);
         eval_and_check(1);
         @(posedge clk);
         advance_model();
         #1;
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
